// File: rtl/packet_injector.sv
// packet_injector
//   Network-interface stage in front of the router input buffer. Collects one
//   packet of 16-bit payload words from the local PE (valid/ready), frames it
//   as header/body.../tail flits, and hands the flits to the buffer with one
//   req/ack handshake per packet followed by one flit per non-ack cycle.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   pe_valid    PE word valid
//   pe_ready    injector accepts a word (COLLECT / DRAIN)
//   pe_data     16-bit payload word
//   pe_last     final word of the packet
//   pe_dest     destination, sampled with the first word
//   out_req     request to the downstream buffer (REQ state)
//   out_ack     acknowledge / stall from the downstream buffer
//   out_data    current flit: [17:16] type, [15:0] payload
//   busy        high whenever not in COLLECT
//   overflow    one-cycle pulse when a packet is truncated
module packet_injector #(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned MAX_PACKET_SIZE = 64,
  parameter int unsigned ADDRESS_SIZE    = 4,
  parameter logic [3:0]  SRC_ID          = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pe_valid,
  output logic                    pe_ready,
  input  logic [15:0]             pe_data,
  input  logic                    pe_last,
  input  logic [ADDRESS_SIZE-1:0] pe_dest,
  output logic                    out_req,
  input  logic                    out_ack,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    busy,
  output logic                    overflow
);

  // Flit type codes; must match the router's flit definitions.
  localparam logic [1:0] FLIT_HEADER = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TAIL   = 2'b11;

  localparam int unsigned CW = $clog2(MAX_PACKET_SIZE) + 1;  // count / index width
  localparam int unsigned AW = $clog2(MAX_PACKET_SIZE - 1);  // store address width
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_PACKET_SIZE - 2);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_DRAIN,
    S_REQ,
    S_HANDOFF,
    S_STREAM
  } state_t;

  state_t        r_state;
  logic [15:0]   r_store [MAX_PACKET_SIZE-1];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic [3:0]    r_dest;
  logic          r_overflow;

  logic          w_take;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [15:0]   w_hdr;
  logic [17:0]   w_flit;

  assign w_take    = pe_valid && pe_ready;
  assign w_wr_addr = AW'(r_count);
  // Flit idx >= 1 carries word idx-1; idx 0 is the header.
  assign w_rd_addr = AW'(r_idx - 1'b1);
  assign w_hdr     = {8'(r_count), SRC_ID, r_dest};
  assign overflow  = r_overflow;

  // Word store: no reset needed, r_count defines which entries are valid.
  always_ff @(posedge clk) begin
    if (r_state == S_COLLECT && w_take) begin
      r_store[w_wr_addr] <= pe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_COLLECT;
      r_count    <= '0;
      r_idx      <= '0;
      r_dest     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_take) begin
            r_count <= r_count + 1'b1;
            if (r_count == '0) begin
              r_dest <= 4'(pe_dest);
            end
            if (pe_last) begin
              r_state <= S_REQ;
            end else if (r_count == LAST_SLOT) begin
              // Store full: this word is kept as the tail, the rest is dropped.
              r_overflow <= 1'b1;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_take && pe_last) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (out_ack) begin
            r_state <= S_HANDOFF;
          end
        end
        S_HANDOFF: begin
          // Buffer still shows ack this cycle; it is not a stall.
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (!out_ack) begin
            if (r_idx == r_count) begin
              r_state <= S_COLLECT;
              r_count <= '0;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  always_comb begin
    w_flit = {FLIT_HEADER, w_hdr};
    if (r_idx != '0) begin
      if (r_idx == r_count) begin
        w_flit = {FLIT_TAIL, r_store[w_rd_addr]};
      end else begin
        w_flit = {FLIT_BODY, r_store[w_rd_addr]};
      end
    end
  end

  always_comb begin
    pe_ready = 1'b0;
    out_req  = 1'b0;
    out_data = '0;
    busy     = 1'b1;
    case (r_state)
      S_COLLECT: begin
        pe_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DRAIN: begin
        pe_ready = 1'b1;
      end
      S_REQ: begin
        out_req  = 1'b1;
        out_data = DATA_WIDTH'({FLIT_HEADER, w_hdr});
      end
      S_HANDOFF: begin
        out_data = DATA_WIDTH'({FLIT_HEADER, w_hdr});
      end
      S_STREAM: begin
        out_data = DATA_WIDTH'(w_flit);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/packet_injector.md
Name: packet_injector

Overview:
- Network-interface stage directly upstream of the router input buffer.
- Collects one packet of 16-bit payload words from the local processing element (PE) over a valid/ready interface.
- Frames the words as 18-bit flits: header, body..., tail.
- Delivers the flits on a ReqAck-style port with the buffer's protocol: one req/ack handshake per packet, then one flit consumed per cycle until the tail.

Parameters:
- DATA_WIDTH, 18, flit width; [17:16] flit type, [15:0] flit payload.
- MAX_PACKET_SIZE, 64, maximum flits per packet including the header; must match the downstream buffer depth.
- ADDRESS_SIZE, 4, destination address width; must be ≤4.
- SRC_ID, 0, 4-bit source node ID placed in the header.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pe_valid  in  1  PE payload word valid.
- pe_ready  out  1  injector can accept a word.
- pe_data  in  16  payload word.
- pe_last  in  1  marks the final word of the packet.
- pe_dest  in  ADDRESS_SIZE  destination; sampled with the first word.
- out_req  out  1  request to the downstream buffer.
- out_ack  in  1  acknowledge from the downstream buffer.
- out_data  out  DATA_WIDTH  current flit.
- busy  out  1  high in any state other than COLLECT.
- overflow  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Synchronous reset, dominant in every state. Reset drives:
  - state = COLLECT, pe_ready = 1.
  - out_req = 0, out_data = 0, overflow = 0.
  - word count and read index = 0; buffered words discarded.
  - Reset in the middle of a transfer abandons the packet; no further flits are driven.
- Flit type codes are FLIT_HEADER, FLIT_BODY and FLIT_TAIL from the shared definitions header.
- Packet framing for N words, 1 ≤ N ≤ MAX_PACKET_SIZE-1:
  - Flit 0 is the header: [15:8] = N, [7:4] = SRC_ID, [3:0] = dest zero-extended.
  - Words 0..N-2 become body flits, in order.
  - Word N-1 becomes the tail flit.
  - Total flits = N+1.
- Internal word store: MAX_PACKET_SIZE-1 entries of 16 bits, plus a count register of 7 bits at the defaults.
- States:
  - COLLECT:
    - pe_ready = 1; a word is transferred when pe_valid && pe_ready and is written at store[count]; count increments.
    - dest is latched on the first word (count == 0).
    - The word with pe_last → REQ on the next cycle.
    - If count == MAX_PACKET_SIZE-2 and the transferred word is not pe_last: that word becomes the tail, overflow pulses for one cycle, → DRAIN.
  - DRAIN:
    - pe_ready = 1; words are accepted and discarded.
    - The word with pe_last → REQ.
  - REQ:
    - pe_ready = 0, out_req = 1, out_data = header.
    - out_ack == 1 → HANDOFF.
  - HANDOFF:
    - out_req = 0, out_data = header held. The downstream buffer still shows ack this cycle.
    - → STREAM unconditionally.
  - STREAM:
    - out_req = 0, out_data = flit[idx].
    - Each cycle with out_ack == 0, the flit on out_data is consumed and idx increments.
    - A cycle with out_ack == 1 stalls: flit is held, idx unchanged.
    - When the tail is consumed → COLLECT, count = 0, idx = 0.
- out_data is 0 in COLLECT and DRAIN.
- Latency:
  - Last word accepted at cycle t → out_req high at t+1.
  - If ack arrives at t+2, the header is consumed at t+4 and the tail at t+4+N.
- N = 1: header followed directly by the tail; no body flits.
- pe_valid while busy (REQ/HANDOFF/STREAM): ignored, because pe_ready = 0. The PE must hold the word.
- pe_dest is ignored after the first word of a packet.

Test Plan:
- Basic 3-word packet: dest=5, words 0xAAAA/0xBBBB/0xCCCC (last on the third), ack held 1 for two cycles → out_data sequence:
  - header 0x0305 with type HEADER;
  - body 0xAAAA, body 0xBBBB;
  - tail 0xCCCC;
  - then COLLECT with pe_ready=1.
- Single-word packet: dest=2, word 0x1234 with last → header with [15:8]=1, then tail 0x1234; no body flit.
- Overflow: 70 words without last until word 70 → 63 words kept (word 62 becomes the tail), overflow pulses exactly once, header length = 63, words 63..69 dropped.
- Stalls: ack re-asserted for 2 cycles mid-stream after flit 2 → flit 2 held stable for those cycles, no flit skipped or duplicated.
- Back-pressure: pe_valid held during STREAM → pe_ready=0, no words accepted until the tail is consumed; the next packet then starts cleanly.
- Mid-stream reset: rst for 1 cycle during STREAM after flit 1 → next cycle out_req=0, out_data=0, pe_ready=1, busy=0; a new packet then frames correctly from header.
